// File: rtl/pn_result_sorter.sv
// Captures a burst of signed results, keeps them sorted on arrival, then replays them one per cycle.
// PN_SORT_ASCENDING_EN selects smallest-first order; by default the largest result comes out first.
module pn_result_sorter #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             busy,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic signed [31:0] buf_q   [DEPTH];
  logic signed [31:0] ins_buf [DEPTH];
  logic [DEPTH-1:0]   keep;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   fill;
  logic [IDX_W-1:0]   rd_idx;
  logic               overflow_q;
  logic signed [31:0] din;
  logic               last_out;

  assign din      = $signed(in_data);
  assign last_out = (CNT_W'(rd_idx) == count_q - CNT_W'(1));

  // keep[i]: entry i stays ahead of the new sample. Ties keep the older entry
  // first, so equal values leave in arrival order.
  always_comb begin
    fill = (state == IDLE) ? '0 : count_q;
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef PN_SORT_ASCENDING_EN
      keep[i] = (i < int'(fill)) && (buf_q[i] <= din);
`else
      keep[i] = (i < int'(fill)) && (buf_q[i] >= din);
`endif
    end
    ins_buf[0] = keep[0] ? buf_q[0] : din;
    for (int i = 1; i < DEPTH; i++) begin
      if (keep[i])          ins_buf[i] = buf_q[i];
      else if (keep[i-1])   ins_buf[i] = din;
      else                  ins_buf[i] = buf_q[i-1];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = COLLECT;
      COLLECT: if (!in_valid) state_nx = OUTPUT;
      OUTPUT:  if (last_out)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count_q    <= '0;
      rd_idx     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= ins_buf[i];
            count_q    <= CNT_W'(1);
            overflow_q <= 1'b0;
          end
          rd_idx <= '0;
        end
        COLLECT: begin
          if (in_valid) begin
            if (count_q == DEPTH_C) begin
              overflow_q <= 1'b1;
            end else begin
              for (int i = 0; i < DEPTH; i++) buf_q[i] <= ins_buf[i];
              count_q <= count_q + CNT_W'(1);
            end
          end
          rd_idx <= '0;
        end
        OUTPUT:  rd_idx <= rd_idx + IDX_W'(1);
        default: rd_idx <= '0;
      endcase
    end
  end

  assign busy      = (state == OUTPUT);
  assign out_valid = busy;
  assign out_data  = busy ? buf_q[rd_idx] : 32'h0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign state_dbg = state;

endmodule
